seq_adder64_ctrl: RTL

//  Multi-cycle sequencer that computes a WIDTH-bit sum using one shared sixteen_bit_adder.
//  It feeds the adder one 16-bit slice per cycle, least-significant slice first, and carries

---
 rtl/seq_adder64_ctrl_pkg.sv | 13 +
 rtl/seq_adder64_ctrl_sixteen_bit_adder.sv | 16 +
 rtl/seq_adder64_ctrl.sv | 116 +++++++++++
 3 files changed

// File: rtl/seq_adder64_ctrl_pkg.sv
// Shared types and constants for the sliced sequential adder.
// The FSM encoding and slice width live here so every file agrees.
package seq_adder64_ctrl_pkg;

    localparam int SLICE = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/seq_adder64_ctrl_sixteen_bit_adder.sv
// One 16-bit slice adder with carry in and carry out.
// Shared by every slice of the sequential add.
module sixteen_bit_adder (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);

    // Purely combinational slice add.
    always_comb begin
        {cout, sum} = {1'b0, a} + {1'b0, b} + {16'b0, cin};
    end

endmodule

// File: rtl/seq_adder64_ctrl.sv
// Multi-cycle adder: one 16-bit slice per cycle, LSB slice first.
// Valid/ready on both sides; one operation in flight.
module seq_adder64_ctrl
    import seq_adder64_ctrl_pkg::*;
#(
    parameter int NSLICE = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SLICE*NSLICE-1:0] A,
    input  logic [SLICE*NSLICE-1:0] B,
    input  logic                    Cin,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SLICE*NSLICE-1:0] S,
    output logic                    Cout,
    output logic                    busy
);

    localparam int WIDTH = SLICE * NSLICE;
    localparam int IDX_W = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NSLICE - 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   s_q, s_d;
    logic               cout_q, cout_d;

    logic [SLICE-1:0]   slc_sum;
    logic               slc_cout;

    sixteen_bit_adder u_add (
        .a    (a_q[idx_q*SLICE +: SLICE]),
        .b    (b_q[idx_q*SLICE +: SLICE]),
        .cin  (carry_q),
        .sum  (slc_sum),
        .cout (slc_cout)
    );

    // Next-state and datapath updates for the IDLE/RUN/DONE sequence.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        cout_d  = cout_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = A;
                    b_d     = B;
                    carry_d = Cin;
                    idx_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                s_d[idx_q*SLICE +: SLICE] = slc_sum;
                carry_d = slc_cout;
                if (idx_q == IDX_LAST) begin
                    cout_d  = slc_cout;
                    idx_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
        end
    end

    // Handshake and status outputs decode directly from state.
    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);
        busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
        S         = s_q;
        Cout      = cout_q;
    end

endmodule
